// File: rtl/capture_if.sv
// Capture stream toward the SDRAM write stage: sample strobe/data, done level,
// and the write-FIFO full status coming back.
interface capture_if #(
  parameter int DW = 16
);
  logic          capture_valid;
  logic [DW-1:0] capture_data;
  logic          capture_done;
  logic          wfifo_full;

  modport master (
    output capture_valid,
    output capture_data,
    output capture_done,
    input  wfifo_full
  );

  modport slave (
    input  capture_valid,
    input  capture_data,
    input  capture_done,
    output wfifo_full
  );
endinterface

// File: rtl/capture_ctrl.sv
// Sample-capture sequencer: decimates the probe bus and runs PRE / ARMED / POST,
// streaming samples to the write stage and recording the trigger ring index.
module capture_ctrl #(
  parameter int DW   = 16,
  parameter int CW   = 32,
  parameter int DIVW = 24
) (
  input  logic            core_clk,
  input  logic            core_rst_n,
  input  logic            sample_en,
  input  logic [DIVW-1:0] sample_div,
  input  logic [CW-1:0]   sample_depth,
  input  logic [CW-1:0]   pre_depth,
  input  logic [CW-1:0]   sample_last_cnt,
  input  logic [DW-1:0]   sample_data,
  input  logic            trig_hit,
  capture_if.master       cap,
  output logic            trig_valid,
  output logic [CW-1:0]   trig_pos,
  output logic            overflow,
  output logic            busy
);

  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;

  state_t          state_q;
  logic [DIVW-1:0] div_cnt_q;
  logic [CW-1:0]   cap_idx_q;
  logic [CW-1:0]   pre_cnt_q;
  logic [CW-1:0]   post_cnt_q;
  logic            sample_en_q;
  logic            capture_valid_q;
  logic [DW-1:0]   capture_data_q;
  logic            capture_done_q;
  logic            trig_valid_q;
  logic [CW-1:0]   trig_pos_q;
  logic            overflow_q;
  logic            busy_q;

  logic            active;
  logic            abort;
  logic            strobe;
  logic            start;
  logic [CW-1:0]   pre_ld_d;
  logic [CW-1:0]   post_ld_d;
  logic [CW-1:0]   cap_idx_d;
  logic [DIVW-1:0] div_cnt_d;

  assign active = (state_q == PRE) || (state_q == ARMED) || (state_q == POST);
  assign abort  = active & ~sample_en;
  // Abort wins: a strobe landing on the abort cycle is never emitted.
  assign strobe = active & sample_en & (div_cnt_q == sample_div);
  assign start  = (state_q == IDLE) & sample_en & ~sample_en_q;

  // Pre-trigger count is clamped so at least one sample is left for the post phase.
  assign pre_ld_d  = (pre_depth < sample_depth) ? pre_depth
                   : ((sample_depth == '0) ? '0 : sample_depth - 1'b1);
  assign post_ld_d = (pre_depth < sample_depth) ? (sample_depth - pre_depth) : CW'(1);
  assign cap_idx_d = (cap_idx_q == sample_last_cnt) ? '0 : cap_idx_q + 1'b1;
  assign div_cnt_d = (active && sample_en && (div_cnt_q != sample_div)) ? div_cnt_q + 1'b1 : '0;

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q         <= IDLE;
      div_cnt_q       <= '0;
      cap_idx_q       <= '0;
      pre_cnt_q       <= '0;
      post_cnt_q      <= '0;
      sample_en_q     <= 1'b0;
      capture_valid_q <= 1'b0;
      capture_data_q  <= '0;
      capture_done_q  <= 1'b0;
      trig_valid_q    <= 1'b0;
      trig_pos_q      <= '0;
      overflow_q      <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      sample_en_q     <= sample_en;
      capture_valid_q <= strobe;
      div_cnt_q       <= div_cnt_d;
      capture_done_q  <= 1'b0;
      if (strobe) begin
        capture_data_q <= sample_data;
        cap_idx_q      <= cap_idx_d;
        if (cap.wfifo_full) overflow_q <= 1'b1;
      end
      if (abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start) begin
            cap_idx_q    <= '0;
            trig_valid_q <= 1'b0;
            trig_pos_q   <= '0;
            overflow_q   <= 1'b0;
            pre_cnt_q    <= pre_ld_d;
            post_cnt_q   <= post_ld_d;
            state_q      <= (pre_ld_d == '0) ? ARMED : PRE;
            busy_q       <= 1'b1;
          end
          PRE: if (strobe) begin
            pre_cnt_q <= pre_cnt_q - 1'b1;
            if (pre_cnt_q == CW'(1)) state_q <= ARMED;
          end
          ARMED: if (strobe && trig_hit) begin
            trig_pos_q   <= cap_idx_q;
            trig_valid_q <= 1'b1;
            post_cnt_q   <= post_cnt_q - 1'b1;
            if (post_cnt_q == CW'(1)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= POST;
            end
          end
          POST: if (strobe) begin
            post_cnt_q <= post_cnt_q - 1'b1;
            if (post_cnt_q == CW'(1)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
            end
          end
          DONE: begin
            // Level is held so a slow-domain synchronizer cannot miss it.
            if (!sample_en) state_q <= IDLE;
            else            capture_done_q <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cap.capture_valid = capture_valid_q;
  assign cap.capture_data  = capture_data_q;
  assign cap.capture_done  = capture_done_q;
  assign trig_valid        = trig_valid_q;
  assign trig_pos          = trig_pos_q;
  assign overflow          = overflow_q;
  assign busy              = busy_q;

endmodule
